// File: rtl/temp_read_scheduler.sv
// rtl/temp_read_scheduler.sv - round-robin scheduler sharing one 1-Wire temperature engine
// Optional TEMP_ALARM_EN adds a sticky over-threshold alarm (alarm_thresh_i, alarm_clr_i, alarm_o).
module temp_read_scheduler #(
    parameter int N_REQ          = 2,
    parameter int PERIOD_CYCLES  = 1000000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] ack_o,
    output logic [15:0]      rsp_data_o,
    output logic             rsp_err_o,
    input  logic             auto_en_i,
    output logic             eng_start_o,
    output logic             eng_abort_o,
    input  logic             eng_done_i,
    input  logic             eng_err_i,
    input  logic [15:0]      eng_data_i,
    output logic [15:0]      last_temp_o,
    output logic             last_valid_o,
    output logic             busy_o,
`ifdef TEMP_ALARM_EN
    input  logic [15:0]      alarm_thresh_i,
    input  logic             alarm_clr_i,
    output logic             alarm_o,
`endif
    output logic [3:0]       grant_id_o
);

    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [3:0] AUTO_ID = 4'(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    grant_q, grant_d;
    logic [3:0]    rr_q;
    logic [PW-1:0] per_q;
    logic          pend_q;
    logic          pend_clr;
    logic [TW-1:0] to_q;
    logic [15:0]   cap_data_q;
    logic          cap_err_q;
    logic [15:0]   last_temp_q;
    logic          last_valid_q;
    logic          found;
    logic [3:0]    pick;
    logic          ext_resp;
    logic          expired;
    logic          per_wrap;

    // Round-robin: first set bit at or above rr, else lowest set bit (the wrap).
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req_i[j] && (4'(j) >= rr_q)) begin
                found = 1'b1;
                pick  = 4'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req_i[j]) begin
                found = 1'b1;
                pick  = 4'(j);
            end
        end
    end

    assign expired  = (to_q == TW'(TIMEOUT_CYCLES - 1));
    assign per_wrap = auto_en_i && (per_q == PW'(PERIOD_CYCLES - 1));
    assign ext_resp = (state_q == S_RESP) && (grant_q != AUTO_ID);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        pend_clr    = 1'b0;
        eng_start_o = 1'b0;
        eng_abort_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = S_START;
                end else if (pend_q) begin
                    grant_d  = AUTO_ID;
                    pend_clr = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                eng_start_o = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done_i) begin
                    state_d = S_RESP;
                end else if (expired) begin
                    eng_abort_o = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_o = '0;
        for (int j = 0; j < N_REQ; j++) begin
            ack_o[j] = ext_resp && (grant_q == 4'(j));
        end
    end

    assign rsp_data_o   = ext_resp ? cap_data_q : 16'h0000;
    assign rsp_err_o    = ext_resp && cap_err_q;
    assign busy_o       = (state_q != S_IDLE);
    assign grant_id_o   = grant_q;
    assign last_temp_o  = last_temp_q;
    assign last_valid_o = last_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            rr_q         <= '0;
            per_q        <= '0;
            pend_q       <= 1'b0;
            to_q         <= '0;
            cap_data_q   <= '0;
            cap_err_q    <= 1'b0;
            last_temp_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;

            if (!auto_en_i || per_wrap) per_q <= '0;
            else                        per_q <= per_q + PW'(1);
            // A fresh wrap beats the clear from a grant in the same cycle.
            if (per_wrap)      pend_q <= 1'b1;
            else if (pend_clr) pend_q <= 1'b0;

            if (state_q == S_START) begin
                to_q <= '0;
            end else if (state_q == S_WAIT) begin
                to_q <= to_q + TW'(1);
                if (eng_done_i) begin
                    cap_data_q <= eng_data_i;
                    cap_err_q  <= eng_err_i;
                end else if (expired) begin
                    cap_data_q <= '0;
                    cap_err_q  <= 1'b1;
                end
            end

            if (state_q == S_RESP) begin
                if (!cap_err_q) begin
                    last_temp_q  <= cap_data_q;
                    last_valid_q <= 1'b1;
                end
                if (grant_q != AUTO_ID) begin
                    rr_q <= (grant_q == 4'(N_REQ - 1)) ? 4'd0 : grant_q + 4'd1;
                end
            end
        end
    end

`ifdef TEMP_ALARM_EN
    logic alarm_q;
    assign alarm_o = alarm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else if ((state_q == S_RESP) && !cap_err_q &&
                     ($signed(cap_data_q) > $signed(alarm_thresh_i))) begin
            alarm_q <= 1'b1;
        end else if (alarm_clr_i) begin
            alarm_q <= 1'b0;
        end
    end
`endif

endmodule
